// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: the VDP has fixed priority, and a starvation limit forces a CPU grant.
// Optional macro VRAM_ARB_STATS_EN adds a saturating CPU stall counter port (cpu_stall_cnt_o).
module vram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_valid_o,
  input  logic              vdp_req_i,
  input  logic [ADDR_W-1:0] vdp_addr_i,
  output logic              vdp_ack_o,
  output logic [DATA_W-1:0] vdp_rdata_o,
  output logic              vdp_valid_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       cpu_stall_cnt_o
`endif
);

  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_CPU  = 2'd1;
  localparam logic [1:0] TAG_VDP  = 2'd2;

  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        tag_q, tag_d;   // travels with the command
  logic [1:0]        rtag_q;         // aligned with mem_rdata
  logic              cpu_win, vdp_win;

  // Grants are gated by reset so nothing is acked while the block is held.
  always_comb begin
    cpu_win = rst_ni & cpu_req_i & (~vdp_req_i | (wait_cnt_q == MAX_WAIT));
    vdp_win = rst_ni & vdp_req_i & ~cpu_win;
  end

  assign cpu_ack_o = cpu_win;
  assign vdp_ack_o = vdp_win;

  always_comb begin
    wait_cnt_d = 4'd0;
    if (cpu_req_i && vdp_win)
      wait_cnt_d = (wait_cnt_q == MAX_WAIT) ? MAX_WAIT : wait_cnt_q + 4'd1;
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tag_d       = TAG_NONE;
    if (cpu_win) begin
      mem_addr_d  = cpu_addr_i;
      mem_wdata_d = cpu_wdata_i;
      tag_d       = cpu_we_i ? TAG_NONE : TAG_CPU;
    end else if (vdp_win) begin
      mem_addr_d  = vdp_addr_i;
      tag_d       = TAG_VDP;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q  <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag_q       <= TAG_NONE;
      rtag_q      <= TAG_NONE;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      mem_en_q    <= cpu_win | vdp_win;
      mem_we_q    <= cpu_win & cpu_we_i;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag_q       <= tag_d;
      rtag_q      <= tag_q;
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  assign cpu_rdata_o = mem_rdata_i;
  assign vdp_rdata_o = mem_rdata_i;
  assign cpu_valid_o = rst_ni & (rtag_q == TAG_CPU);
  assign vdp_valid_o = rst_ni & (rtag_q == TAG_VDP);

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      stall_q <= 16'd0;
    else if (cpu_req_i && !cpu_win && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign cpu_stall_cnt_o = stall_q;
`endif

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous RAM between the CPU bus and the VDP pixel/tile fetch path.
- Fixed priority to the VDP, plus a starvation limit that guarantees the CPU a slot after a bounded number of lost cycles.
- Registers the winning command toward the RAM and routes read data back to its originator with a valid pulse.
- Sits between cpu/vdp and ram in the top-level, below the FFF0-FFFF register decode.

Parameters:
- ADDR_W, 16, address width of both requesters and RAM.
- DATA_W, 8, data width.
- CPU_MAX_WAIT, 4, consecutive contended cycles the CPU may lose before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  request accepted this cycle (combinational).
- cpu_rdata  out  DATA_W  read data for CPU.
- cpu_valid  out  1  cpu_rdata valid, one-cycle pulse.
- vdp_req  in  1  VDP read request, held until vdp_ack.
- vdp_addr  in  ADDR_W  VDP address; the VDP is read-only.
- vdp_ack  out  1  request accepted this cycle (combinational).
- vdp_rdata  out  DATA_W  read data for VDP.
- vdp_valid  out  1  vdp_rdata valid, one-cycle pulse.
- mem_en  out  1  registered RAM enable.
- mem_we  out  1  registered RAM write enable.
- mem_addr  out  ADDR_W  registered RAM address.
- mem_wdata  out  DATA_W  registered RAM write data.
- mem_rdata  in  DATA_W  RAM read data, one cycle after mem_en.

Behaviour:
- Reset (reset=0, asynchronous):
  - mem_en, mem_we, mem_addr, mem_wdata = 0.
  - Starvation counter = 0; read tag = NONE.
  - cpu_ack, vdp_ack, cpu_valid, vdp_valid = 0; they are gated while reset is low.
  - cpu_rdata and vdp_rdata are driven from mem_rdata and are don't-care when their valid is low.
- Arbitration (combinational, cycle N):
  - Only vdp_req: VDP wins.
  - Only cpu_req: CPU wins.
  - Both: VDP wins unless wait_cnt == CPU_MAX_WAIT, in which case CPU wins.
  - Exactly one ack is high, for the winner.
  - A requester that sees ack in cycle N must present a new request or drop req at N+1. A held req at N+1 is a new access.
- Starvation counter (wait_cnt, 4 bits):
  - Increments when both request and the VDP wins.
  - Clears to 0 when the CPU wins or cpu_req is low.
  - Never exceeds CPU_MAX_WAIT.
- Command issue:
  - At the edge ending cycle N, the winner's addr/we/wdata are registered to the mem_* outputs, with mem_en=1.
  - No winner: mem_en=0 and mem_we=0; mem_addr and mem_wdata hold.
  - VDP accesses always register mem_we=0.
- Read return:
  - A read issued at N+1 returns on mem_rdata at N+2.
  - A 2-bit tag (NONE/CPU/VDP), registered with the command, selects the valid pulse at N+2.
  - Writes set the tag to NONE and produce no valid.
- Throughput: back-to-back accesses, one per cycle, with reads pipelined. Read latency from ack is 2 cycles.
- Reset mid-operation: an in-flight read is discarded, so no valid pulse follows deassertion. The first grant after reset release follows the normal rules with wait_cnt=0.

Optional Feature:
- Macro VRAM_ARB_STATS_EN.
- Defined:
  - Extra output port cpu_stall_cnt, 16 bits.
  - Counts cycles with cpu_req=1 and cpu_ack=0.
  - Saturates at 16'hFFFF; cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- CPU-only write then read: write 0x1234 <- 0xA5, then read 0x1234. Expect cpu_ack in the request cycle, mem_en/mem_we=1/mem_addr=0x1234 the next cycle, then cpu_valid with cpu_rdata=0xA5 two cycles after the read ack, and vdp_valid never asserted.
- Continuous contention, CPU_MAX_WAIT=4: vdp_req and cpu_req held high for 12 cycles. Expect grant pattern V,V,V,V,C,V,V,V,V,C,V,V.
- VDP streaming reads 0x4000..0x4007, one per cycle, with no CPU request. Expect 8 vdp_ack cycles and 8 consecutive vdp_valid pulses with rdata matching RAM contents, each 2 cycles after its ack.
- Interleaved tags: CPU read 0x0010 (RAM 0x11) in cycle 0, then VDP read 0x0020 (RAM 0x22) in cycle 1. Expect cpu_valid/0x11 at cycle 2 and vdp_valid/0x22 at cycle 3, with no cross-routing.
- Reset mid-read: reset=0 asserted in the cycle after a CPU read ack. Expect mem_en=0 immediately and no cpu_valid after release. A fresh request after release is acked with wait_cnt=0.
- With VRAM_ARB_STATS_EN: CPU starved 4 cycles, 3 times. Expect cpu_stall_cnt=12. Forcing 70000 stall cycles leaves it at 0xFFFF.
